// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, read-mode constants and sizing helpers for the FIFO family.
package fifo_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int FIFO_STD   = 0;
  localparam int FIFO_FWFT  = 1;
  function automatic int fifo_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/fifo_flag_gen.sv
// fifo_flag_gen: decodes occupancy count into full/empty and threshold flags.
module fifo_flag_gen #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty
);
  always_comb begin
    full         = count == CW'(DEPTH);
    empty        = count == '0;
    almost_full  = count >= CW'(AF_LEVEL);
    almost_empty = count <= CW'(AE_LEVEL);
  end
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, threshold flags, error pulses and optional FWFT read.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_STD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = fifo_aw(DEPTH);
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range");
  end
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic overflow_q, underflow_q, wr_acc, rd_acc;
  logic [AW-1:0] wr_addr, rd_addr;
  always_comb begin
    wr_addr  = wr_ptr_q[AW-1:0];
    rd_addr  = rd_ptr_q[AW-1:0];
    count    = wr_ptr_q - rd_ptr_q;
    rd_acc   = rd_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end
  fifo_flag_gen #(
    .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .CW(AW + 1)
  ) u_flags (
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end
  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= data_in;
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign data_out = empty ? '0 : mem_q[rd_addr];
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) dout_q <= '0;
      else if (rd_acc) dout_q <= mem_q[rd_addr];
    end
    assign data_out = dout_q;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table vectors plus scoreboard checks on standard and FWFT instances.
module tb_sync_fifo_param;
  logic clk = 0, rst = 0, wr_en = 0, rd_en = 0;
  logic [3:0] data_in = 0;
  logic [3:0] dout0, dout1;
  logic [4:0] cnt0, cnt1;
  logic full0, empty0, af0, ae0, ov0, un0;
  logic full1, empty1, af1, ae1, ov1, un1;
  int n = 0, fails = 0;
  logic [3:0] q[$];
  logic [3:0] sb[$];
  logic [3:0] std_exp = 0;
  typedef struct {
    logic wr;
    logic rd;
    logic [3:0] din;
    int cnt;
    logic ov;
    logic un;
  } vec_t;
  vec_t tv[34];
  always #5 clk = ~clk;
  sync_fifo_param #(.DATA_W(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0)
  );
  sync_fifo_param #(.DATA_W(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic [3:0] d);
    logic wa, ra, eov, eun;
    int c;
    @(negedge clk);
    wr_en = w; rd_en = r; data_in = d;
    ra = r && q.size() > 0;
    wa = w && (q.size() < 16 || ra);
    if (ra) sb.push_back(q.pop_front());
    if (wa) q.push_back(d);
    eov = w && !wa;
    eun = r && !ra;
    @(posedge clk);
    #1;
    if (sb.size() > 0) std_exp = sb.pop_front();
    c = q.size();
    chk("count", 32'(cnt0), 32'(c));
    chk("full", 32'(full0), 32'(c == 16));
    chk("empty", 32'(empty0), 32'(c == 0));
    chk("almost_full", 32'(af0), 32'(c >= 14));
    chk("almost_empty", 32'(ae0), 32'(c <= 2));
    chk("overflow", 32'(ov0), 32'(eov));
    chk("underflow", 32'(un0), 32'(eun));
    chk("data_out_std", 32'(dout0), 32'(std_exp));
    chk("fwft_count", 32'(cnt1), 32'(c));
    chk("fwft_empty", 32'(empty1), 32'(c == 0));
    chk("fwft_flags", {full1, af1, ae1, ov1, un1}, {full0, af0, ae0, ov0, un0});
    if (c > 0) chk("data_out_fwft", 32'(dout1), 32'(q[0]));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; wr_en = 0; rd_en = 0;
    #1;
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_almost_empty", 32'(ae0), 1);
    chk("rst_full", 32'({full0, af0}), 0);
    chk("rst_pulses", 32'({ov0, un0}), 0);
    chk("rst_data_out", 32'(dout0), 0);
    chk("rst_data_out_fwft", 32'(dout1), 0);
    @(negedge clk);
    rst = 0;
    q.delete();
    sb.delete();
    std_exp = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 17; i++) tv[i] = '{1'b1, 1'b0, 4'(i), (i < 16) ? i + 1 : 16, i == 16, 1'b0};
    for (int i = 0; i < 17; i++) tv[17 + i] = '{1'b0, 1'b1, 4'(0), (i < 16) ? 15 - i : 0, 1'b0, i == 16};
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 4'(i + 3));
    do_reset();
    step(0, 0, 0);
    for (int i = 0; i < 34; i++) begin
      step(tv[i].wr, tv[i].rd, tv[i].din);
      chk("tbl_count", 32'(cnt0), 32'(tv[i].cnt));
      chk("tbl_overflow", 32'(ov0), 32'(tv[i].ov));
      chk("tbl_underflow", 32'(un0), 32'(tv[i].un));
    end
    chk("drain_hold", 32'(dout0), 15);
    for (int i = 0; i < 4; i++) step(1, 0, 4'(i));
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0);
      step(1, 0, 4'((i + 4) % 16));
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i));
    step(1, 1, 4'hA);
    chk("sim_full_count", 32'(cnt0), 16);
    chk("sim_full_no_ovf", 32'(ov0), 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    chk("sim_full_new_word", 32'(dout0), 32'hA);
    step(1, 1, 4'h7);
    chk("sim_empty_underflow", 32'(un0), 1);
    chk("sim_empty_count", 32'(cnt0), 1);
    do_reset();
    step(1, 0, 4'h9);
    chk("fwft_head", 32'(dout1), 9);
    chk("fwft_not_empty", 32'(empty1), 0);
    step(1, 0, 4'h3);
    step(0, 1, 0);
    chk("fwft_next_head", 32'(dout1), 3);
    for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
